// File: rtl/sync_fifo_pkg.sv
// Shared types for the single-clock show-ahead FIFO.
// Bundles the four occupancy flags so the top decodes them in one place.
package sync_fifo_pkg;

    typedef struct packed {
        logic full;
        logic afull;
        logic empty;
        logic aempty;
    } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset; the pointers alone define validity.
module sync_fifo_mem #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_r [DEPTH];

    // Write port: store the pushed word at the write address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO of 2**ASIZE words; the head word is always on rdata.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             awfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             arempty
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] AFULL_LVL  = (ASIZE+1)'(DEPTH - 1);
    localparam logic [ASIZE:0] AEMPTY_LVL = (ASIZE+1)'(1);
    localparam logic [ASIZE:0] PTR_ONE    = (ASIZE+1)'(1);

    logic [ASIZE:0] wptr_r;
    logic [ASIZE:0] rptr_r;
    logic [ASIZE:0] count_s;
    logic           do_push_s;
    logic           do_pop_s;
    fifo_flags_t    flags_s;

    // Overflow pushes and underflow pops are simply not accepted.
    assign do_push_s = winc && !flags_s.full;
    assign do_pop_s  = rinc && !flags_s.empty;

    // Pointer registers: advance on accepted push/pop, cleared by async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
        end
    end

    // Flag decode from the registered pointers; count wraps modulo 2**(ASIZE+1).
    always_comb begin
        flags_s = '0;
        count_s = wptr_r - rptr_r;
        flags_s.empty  = (wptr_r == rptr_r);
        flags_s.full   = (wptr_r[ASIZE] != rptr_r[ASIZE]) &&
                         (wptr_r[ASIZE-1:0] == rptr_r[ASIZE-1:0]);
        flags_s.afull  = (count_s >= AFULL_LVL);
        flags_s.aempty = (count_s <= AEMPTY_LVL);
    end

    assign wfull   = flags_s.full;
    assign awfull  = flags_s.afull;
    assign rempty  = flags_s.empty;
    assign arempty = flags_s.aempty;

    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (clk),
        .we    (do_push_s && !rst),
        .waddr (wptr_r[ASIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr_r[ASIZE-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DSIZE=33, ASIZE=2) against a queue-based reference.
// Inputs change on the falling edge; outputs are compared on the next falling edge.
module tb_sync_fifo;

    localparam int DSIZE = 33;
    localparam int ASIZE = 2;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             awfull;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             arempty;

    logic [DSIZE-1:0] model_q [$];
    int               n_cmp;
    int               n_bad;

    sync_fifo #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .winc    (winc),
        .wdata   (wdata),
        .wfull   (wfull),
        .awfull  (awfull),
        .rinc    (rinc),
        .rdata   (rdata),
        .rempty  (rempty),
        .arempty (arempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DSIZE-1:0] obs, input logic [DSIZE-1:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every output against what the reference queue implies.
    task automatic check_state(input string tag);
        int n;
        n = model_q.size();
        check_eq({tag, ".rempty"},  {32'd0, rempty},  {32'd0, (n == 0)});
        check_eq({tag, ".arempty"}, {32'd0, arempty}, {32'd0, (n <= 1)});
        check_eq({tag, ".awfull"},  {32'd0, awfull},  {32'd0, (n >= DEPTH - 1)});
        check_eq({tag, ".wfull"},   {32'd0, wfull},   {32'd0, (n == DEPTH)});
        if (n > 0) begin
            check_eq({tag, ".rdata"}, rdata, model_q[0]);
        end
    endtask

    // One clock: apply inputs, update the reference at the edge, check at the next falling edge.
    task automatic cycle(input string tag, input logic w, input logic [DSIZE-1:0] d, input logic r);
        int  n;
        bit  pop_ok;
        bit  push_ok;
        winc  = w;
        wdata = d;
        rinc  = r;
        n = model_q.size();
        pop_ok  = r && (n > 0);
        push_ok = w && (n < DEPTH);
        @(posedge clk);
        if (pop_ok) begin
            void'(model_q.pop_front());
        end
        if (push_ok) begin
            model_q.push_back(d);
        end
        @(negedge clk);
        winc = 1'b0;
        rinc = 1'b0;
        check_state(tag);
    endtask

    // Raise reset between edges and expect the flags to clear before any clock edge.
    task automatic apply_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        check_eq({tag, ".rempty"},  {32'd0, rempty},  33'd1);
        check_eq({tag, ".arempty"}, {32'd0, arempty}, 33'd1);
        check_eq({tag, ".wfull"},   {32'd0, wfull},   33'd0);
        check_eq({tag, ".awfull"},  {32'd0, awfull},  33'd0);
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 33'h0_DEAD_BEEF;
        @(negedge clk);
        check_state({tag, ".held"});
        winc = 1'b0;
        rinc = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        check_state({tag, ".released"});
    endtask

    task automatic drain(input string tag);
        while (model_q.size() > 0) begin
            cycle(tag, 1'b0, 33'd0, 1'b1);
        end
    endtask

    task automatic random_run(input string tag, input int cycles);
        logic [DSIZE-1:0] d;
        for (int i = 0; i < cycles; i++) begin
            d = {1'($urandom_range(1, 0)), 32'($urandom)};
            cycle(tag, 1'($urandom_range(1, 0)), d, 1'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        logic [DSIZE-1:0] seq;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = '0;
        #1;
        check_eq("por.rempty",  {32'd0, rempty},  33'd1);
        check_eq("por.arempty", {32'd0, arempty}, 33'd1);
        check_eq("por.wfull",   {32'd0, wfull},   33'd0);
        check_eq("por.awfull",  {32'd0, awfull},  33'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_state("idle");

        cycle("push_first", 1'b1, 33'h1_0000_0010, 1'b0);
        cycle("pop_first",  1'b0, 33'd0, 1'b1);

        for (int i = 1; i <= 4; i++) begin
            cycle($sformatf("fill%0d", i), 1'b1, 33'(i), 1'b0);
        end
        cycle("push_full", 1'b1, 33'd5, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            check_eq($sformatf("order%0d", i), rdata, 33'(i));
            cycle($sformatf("drain%0d", i), 1'b0, 33'd0, 1'b1);
        end

        cycle("two_a", 1'b1, 33'h0_0000_00A1, 1'b0);
        cycle("two_b", 1'b1, 33'h0_0000_00A2, 1'b0);
        cycle("simul", 1'b1, 33'h0_0000_00A3, 1'b1);
        check_eq("simul.head", rdata, 33'h0_0000_00A2);
        drain("drain_simul");

        cycle("empty_wr", 1'b1, 33'h1_5555_AAAA, 1'b1);
        drain("drain_empty_wr");

        seq = 33'h0_0000_0100;
        for (int round = 0; round < 10; round++) begin
            for (int k = 0; k < 3; k++) begin
                cycle($sformatf("wrap_push_r%0d", round), 1'b1, seq, 1'b0);
                seq = seq + 33'd1;
            end
            for (int k = 0; k < 3; k++) begin
                cycle($sformatf("wrap_pop_r%0d", round), 1'b0, 33'd0, 1'b1);
            end
        end

        for (int i = 0; i < 4; i++) begin
            cycle("refill", 1'b1, 33'h1_0000_0000 + 33'(i), 1'b0);
        end
        cycle("full_simul", 1'b1, 33'h0_0000_0077, 1'b1);
        check_eq("full_simul.head", rdata, 33'h1_0000_0001);

        apply_reset("mid_reset");
        random_run("rand_a", 400);
        apply_reset("rand_reset");
        random_run("rand_b", 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
